// File: rtl/axi_memory_bridge.sv
// AXI4-Lite slave bridging bus reads/writes onto the on-chip memory's
// single-cycle load/store strobes, one access in flight at a time.
//
// Ports:
//   clk_i, rst_n_i           clock, async active-low reset
//   axi_aw*/axi_w*/axi_b*    AXI4-Lite write address/data/response
//   axi_ar*/axi_r*           AXI4-Lite read address/data
//   store_o, store_*_o       store strobe, byte address, data, byte enables
//   store_done_i             store acknowledge
//   load_o, load_address_o   load strobe and byte address
//   load_data_i, load_done_i load data and acknowledge
module axi_memory_bridge #(
   parameter int          MEMORY_SIZE  = 1024,
   parameter logic [31:0] BASE_ADDRESS = 32'h0,
   localparam int         MEM_ADDR_W   = $clog2(MEMORY_SIZE)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [31:0]           axi_awaddr_i,
   input  logic                  axi_awvalid_i,
   output logic                  axi_awready_o,
   input  logic [31:0]           axi_wdata_i,
   input  logic [3:0]            axi_wstrb_i,
   input  logic                  axi_wvalid_i,
   output logic                  axi_wready_o,
   output logic [1:0]            axi_bresp_o,
   output logic                  axi_bvalid_o,
   input  logic                  axi_bready_i,
   input  logic [31:0]           axi_araddr_i,
   input  logic                  axi_arvalid_i,
   output logic                  axi_arready_o,
   output logic [31:0]           axi_rdata_o,
   output logic [1:0]            axi_rresp_o,
   output logic                  axi_rvalid_o,
   input  logic                  axi_rready_i,
   output logic                  store_o,
   output logic [MEM_ADDR_W-1:0] store_address_o,
   output logic [31:0]           store_data_o,
   output logic [3:0]            store_width_o,
   input  logic                  store_done_i,
   output logic                  load_o,
   output logic [MEM_ADDR_W-1:0] load_address_o,
   input  logic [31:0]           load_data_i,
   input  logic                  load_done_i
);

   typedef enum logic [2:0] {
      IDLE, LOAD, LOAD_WAIT, READ_RESP,
      STORE, STORE_WAIT, WRITE_RESP
   } state_e;

   localparam logic GRANT_READ  = 1'b0;
   localparam logic GRANT_WRITE = 1'b1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_e state_q;
   logic   last_grant_q;

   logic        ar_full_q, aw_full_q, w_full_q;
   logic [31:0] ar_addr_q, aw_addr_q, w_data_q;
   logic [3:0]  w_strb_q;

   logic                  load_q, store_q;
   logic [MEM_ADDR_W-1:0] load_addr_q, store_addr_q;
   logic [31:0]           store_data_q, rdata_q;
   logic [3:0]            store_width_q;
   logic [1:0]            rresp_q, bresp_q;
   logic                  rvalid_q, bvalid_q;

   logic rd_pend, wr_pend, grant_rd, grant_wr;
   logic ar_in_range, aw_in_range;

   // Writes need both halves buffered; ties go opposite the last grant.
   assign rd_pend  = ar_full_q;
   assign wr_pend  = aw_full_q & w_full_q;
   assign grant_rd = (state_q == IDLE) & rd_pend &
                     (~wr_pend | (last_grant_q == GRANT_WRITE));
   assign grant_wr = (state_q == IDLE) & wr_pend & ~grant_rd;

   assign ar_in_range = ar_addr_q[31:MEM_ADDR_W] ==
                        BASE_ADDRESS[31:MEM_ADDR_W];
   assign aw_in_range = aw_addr_q[31:MEM_ADDR_W] ==
                        BASE_ADDRESS[31:MEM_ADDR_W];

   assign axi_arready_o = ~ar_full_q;
   assign axi_awready_o = ~aw_full_q;
   assign axi_wready_o  = ~w_full_q;

   // One-entry channel buffers; release happens on the grant out of IDLE.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ar_full_q <= 1'b0;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         ar_addr_q <= '0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (axi_arvalid_i && !ar_full_q) begin
            ar_full_q <= 1'b1;
            ar_addr_q <= axi_araddr_i;
         end else if (grant_rd) begin
            ar_full_q <= 1'b0;
         end
         if (axi_awvalid_i && !aw_full_q) begin
            aw_full_q <= 1'b1;
            aw_addr_q <= axi_awaddr_i;
         end else if (grant_wr) begin
            aw_full_q <= 1'b0;
         end
         if (axi_wvalid_i && !w_full_q) begin
            w_full_q <= 1'b1;
            w_data_q <= axi_wdata_i;
            w_strb_q <= axi_wstrb_i;
         end else if (grant_wr) begin
            w_full_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= IDLE;
         last_grant_q  <= GRANT_WRITE;
         load_q        <= 1'b0;
         store_q       <= 1'b0;
         load_addr_q   <= '0;
         store_addr_q  <= '0;
         store_data_q  <= '0;
         store_width_q <= '0;
         rdata_q       <= '0;
         rresp_q       <= RESP_OKAY;
         bresp_q       <= RESP_OKAY;
         rvalid_q      <= 1'b0;
         bvalid_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_rd) begin
                  last_grant_q <= GRANT_READ;
                  if (ar_in_range) begin
                     state_q     <= LOAD;
                     load_q      <= 1'b1;
                     load_addr_q <= ar_addr_q[MEM_ADDR_W-1:0];
                  end else begin
                     state_q  <= READ_RESP;
                     rvalid_q <= 1'b1;
                     rresp_q  <= RESP_SLVERR;
                     rdata_q  <= '0;
                  end
               end else if (grant_wr) begin
                  last_grant_q <= GRANT_WRITE;
                  if (aw_in_range) begin
                     state_q       <= STORE;
                     store_q       <= 1'b1;
                     store_addr_q  <= aw_addr_q[MEM_ADDR_W-1:0];
                     store_data_q  <= w_data_q;
                     store_width_q <= w_strb_q;
                  end else begin
                     state_q  <= WRITE_RESP;
                     bvalid_q <= 1'b1;
                     bresp_q  <= RESP_SLVERR;
                  end
               end
            end
            LOAD: begin
               load_q  <= 1'b0;
               state_q <= LOAD_WAIT;
            end
            LOAD_WAIT: begin
               if (load_done_i) begin
                  rdata_q  <= load_data_i;
                  rresp_q  <= RESP_OKAY;
                  rvalid_q <= 1'b1;
                  state_q  <= READ_RESP;
               end
            end
            READ_RESP: begin
               if (axi_rready_i) begin
                  rvalid_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            STORE: begin
               store_q <= 1'b0;
               state_q <= STORE_WAIT;
            end
            STORE_WAIT: begin
               if (store_done_i) begin
                  bresp_q  <= RESP_OKAY;
                  bvalid_q <= 1'b1;
                  state_q  <= WRITE_RESP;
               end
            end
            WRITE_RESP: begin
               if (axi_bready_i) begin
                  bvalid_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign load_o          = load_q;
   assign load_address_o  = load_addr_q;
   assign store_o         = store_q;
   assign store_address_o = store_addr_q;
   assign store_data_o    = store_data_q;
   assign store_width_o   = store_width_q;
   assign axi_rdata_o     = rdata_q;
   assign axi_rresp_o     = rresp_q;
   assign axi_rvalid_o    = rvalid_q;
   assign axi_bresp_o     = bresp_q;
   assign axi_bvalid_o    = bvalid_q;

endmodule

// File: tb/tb_axi_memory_bridge.sv
// Bench for axi_memory_bridge: vector table plus directed
// multi-cycle sequences against a zero-wait memory model.
module tb_axi_memory_bridge;

   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic store_o, load_o;
   logic [AW-1:0] store_addr, load_addr;
   logic [31:0] store_data;
   logic [3:0]  store_width;
   logic store_done = 0, load_done = 0;
   logic [31:0] load_data = '0;

   axi_memory_bridge #(.MEMORY_SIZE(1024), .BASE_ADDRESS(32'h0)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .axi_awaddr_i(awaddr), .axi_awvalid_i(awvalid),
      .axi_awready_o(awready),
      .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wvalid_i(wvalid),
      .axi_wready_o(wready),
      .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
      .axi_araddr_i(araddr), .axi_arvalid_i(arvalid),
      .axi_arready_o(arready),
      .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rvalid_o(rvalid),
      .axi_rready_i(rready),
      .store_o(store_o), .store_address_o(store_addr),
      .store_data_o(store_data), .store_width_o(store_width),
      .store_done_i(store_done),
      .load_o(load_o), .load_address_o(load_addr),
      .load_data_i(load_data), .load_done_i(load_done)
   );

   // Zero-wait memory: acknowledge the cycle after each strobe.
   logic [31:0] mem [0:255];

   function automatic logic [31:0] merge(logic [31:0] old,
                                         logic [31:0] nw,
                                         logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      load_done  <= load_o;
      store_done <= store_o;
      if (load_o) load_data <= mem[load_addr[9:2]];
      if (store_o)
         mem[store_addr[9:2]] <= merge(mem[store_addr[9:2]],
                                       store_data, store_width);
   end

   // Strobe monitor.
   int n_load = 0, n_store = 0, n_ovl = 0, n_acc = 0;
   logic order_a [0:63];
   logic [3:0] last_width = '0;
   always @(posedge clk) begin
      if (load_o) n_load <= n_load + 1;
      if (store_o) begin
         n_store    <= n_store + 1;
         last_width <= store_width;
      end
      if (load_o && store_o) n_ovl <= n_ovl + 1;
      if (load_o || store_o) begin
         if (n_acc < 64) order_a[n_acc] <= store_o;
         n_acc <= n_acc + 1;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [1:0] resp,
                           output logic [31:0] d);
      int n;
      araddr = a;
      arvalid = 1;
      n = 0;
      while (!arready && n < 50) begin tick(); n++; end
      tick();
      arvalid = 0;
      n = 0;
      while (!rvalid && n < 50) begin tick(); n++; end
      chk("rd_timeout", 32'(n < 50), 32'd1);
      resp = rresp;
      d = rdata;
      rready = 1;
      tick();
      rready = 0;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      int n;
      logic ha, hw;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1; wvalid = 1;
      n = 0;
      while ((awvalid || wvalid) && n < 50) begin
         ha = awvalid && awready;
         hw = wvalid && wready;
         tick();
         if (ha) awvalid = 0;
         if (hw) wvalid = 0;
         n++;
      end
      n = 0;
      while (!bvalid && n < 50) begin tick(); n++; end
      chk("wr_timeout", 32'(n < 50), 32'd1);
      resp = bresp;
      bready = 1;
      tick();
      bready = 0;
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          nacc;
   } vec_t;

   vec_t vt [0:17];

   initial begin
      logic [1:0]  r;
      logic [31:0] d, hold;
      int nl, ns, base, n;

      vt[0]  = '{1, 32'h10,  32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 1};
      vt[1]  = '{0, 32'h10,  32'h0, 4'h0, 2'b00, 32'hDEADBEEF, 1};
      vt[2]  = '{1, 32'h20,  32'h11223344, 4'hF, 2'b00, 32'h0, 1};
      vt[3]  = '{1, 32'h20,  32'hAABBCCDD, 4'h3, 2'b00, 32'h0, 1};
      vt[4]  = '{0, 32'h20,  32'h0, 4'h0, 2'b00, 32'h1122CCDD, 1};
      vt[5]  = '{1, 32'h24,  32'h55667788, 4'hF, 2'b00, 32'h0, 1};
      vt[6]  = '{1, 32'h24,  32'hFFFFFFFF, 4'h0, 2'b00, 32'h0, 1};
      vt[7]  = '{0, 32'h24,  32'h0, 4'h0, 2'b00, 32'h55667788, 1};
      vt[8]  = '{1, 32'h30,  32'h00000000, 4'hF, 2'b00, 32'h0, 1};
      vt[9]  = '{1, 32'h30,  32'h12345678, 4'h4, 2'b00, 32'h0, 1};
      vt[10] = '{0, 32'h30,  32'h0, 4'h0, 2'b00, 32'h00340000, 1};
      vt[11] = '{1, 32'h3FC, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0, 1};
      vt[12] = '{1, 32'h0,   32'hA5A5A5A5, 4'hF, 2'b00, 32'h0, 1};
      vt[13] = '{0, 32'h3FC, 32'h0, 4'h0, 2'b00, 32'hCAFEF00D, 1};
      vt[14] = '{1, 32'h400, 32'h11111111, 4'hF, 2'b10, 32'h0, 0};
      vt[15] = '{0, 32'h400, 32'h0, 4'h0, 2'b10, 32'h0, 0};
      vt[16] = '{0, 32'h0,   32'h0, 4'h0, 2'b00, 32'hA5A5A5A5, 1};
      vt[17] = '{0, 32'hFFFFFC10, 32'h0, 4'h0, 2'b10, 32'h0, 0};

      // Reset values.
      tick();
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_awready", 32'(awready), 32'd1);
      chk("rst_wready", 32'(wready), 32'd1);
      chk("rst_valids", {29'd0, rvalid, bvalid, load_o | store_o}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_resps", {28'd0, rresp, bresp}, 32'd0);
      chk("rst_store_out", store_data | 32'(store_addr) | 32'(store_width),
          32'd0);
      chk("rst_load_addr", 32'(load_addr), 32'd0);
      tick();
      rst_n = 1;
      tick();

      for (int i = 0; i < 18; i++) begin
         nl = n_load; ns = n_store;
         if (vt[i].wr) begin
            axi_write(vt[i].addr, vt[i].wdata, vt[i].strb, r);
         end else begin
            axi_read(vt[i].addr, r, d);
            chk($sformatf("v%0d_rdata", i), d, vt[i].rdata);
         end
         tick();
         chk($sformatf("v%0d_resp", i), 32'(r), 32'(vt[i].resp));
         chk($sformatf("v%0d_nacc", i),
             32'((n_load - nl) + (n_store - ns)), 32'(vt[i].nacc));
         if (vt[i].wr && vt[i].nacc == 1)
            chk($sformatf("v%0d_width", i), 32'(last_width),
                32'(vt[i].strb));
      end

      // Exact read latency: handshake in cycle 0.
      nl = n_load;
      araddr = 32'h10; arvalid = 1;
      tick();
      arvalid = 0;
      chk("lat_c1_load", 32'(load_o), 32'd0);
      tick();
      chk("lat_c2_load", 32'(load_o), 32'd1);
      chk("lat_c2_addr", 32'(load_addr), 32'h10);
      tick();
      chk("lat_c3_load", 32'(load_o), 32'd0);
      chk("lat_c3_rvalid", 32'(rvalid), 32'd0);
      tick();
      chk("lat_c4_rvalid", 32'(rvalid), 32'd1);
      chk("lat_c4_rdata", rdata, 32'hDEADBEEF);
      chk("lat_c4_rresp", 32'(rresp), 32'd0);
      chk("lat_one_pulse", 32'(n_load - nl), 32'd1);
      rready = 1;
      tick();
      rready = 0;
      chk("lat_rvalid_drop", 32'(rvalid), 32'd0);

      // Out-of-range latency: response one cycle after the grant.
      araddr = 32'h400; arvalid = 1;
      tick();
      arvalid = 0;
      chk("oor_c1_rvalid", 32'(rvalid), 32'd0);
      tick();
      chk("oor_c2_rvalid", 32'(rvalid), 32'd1);
      chk("oor_c2_resp", 32'(rresp), 32'd2);
      chk("oor_c2_rdata", rdata, 32'd0);
      rready = 1;
      tick();
      rready = 0;

      // Ties after a write: R,W repeated four times.
      axi_write(32'h4, 32'h0, 4'hF, r);
      tick();
      base = n_acc;
      rready = 1; bready = 1;
      for (int k = 0; k < 4; k++) begin
         araddr = 32'h0; awaddr = 32'h4;
         wdata = 32'(k); wstrb = 4'hF;
         arvalid = 1; awvalid = 1; wvalid = 1;
         tick();
         arvalid = 0; awvalid = 0; wvalid = 0;
         repeat (14) tick();
      end
      for (int k = 0; k < 8; k++)
         chk($sformatf("tie_order%0d", k), 32'(order_a[base + k]),
             32'(k % 2));
      chk("tie_count", 32'(n_acc - base), 32'd8);

      // Tie after a lone read goes to the write first.
      araddr = 32'h0; arvalid = 1;
      tick();
      arvalid = 0;
      repeat (8) tick();
      base = n_acc;
      arvalid = 1; awvalid = 1; wvalid = 1;
      tick();
      arvalid = 0; awvalid = 0; wvalid = 0;
      repeat (14) tick();
      chk("tie2_first_w", 32'(order_a[base]), 32'd1);
      chk("tie2_second_r", 32'(order_a[base + 1]), 32'd0);
      rready = 0; bready = 0;

      // W arrives three cycles before AW.
      ns = n_store;
      wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1;
      tick();
      wvalid = 0;
      chk("wfirst_wready", 32'(wready), 32'd0);
      tick(); tick();
      chk("wfirst_no_store", 32'(n_store - ns), 32'd0);
      awaddr = 32'h40; awvalid = 1;
      tick();
      awvalid = 0;
      n = 0;
      while (!bvalid && n < 50) begin tick(); n++; end
      chk("wfirst_bvalid", 32'(bvalid), 32'd1);
      chk("wfirst_bresp", 32'(bresp), 32'd0);
      bready = 1;
      tick();
      bready = 0;
      chk("wfirst_one_store", 32'(n_store - ns), 32'd1);
      axi_read(32'h40, r, d);
      chk("wfirst_readback", d, 32'h0BADF00D);

      // Read backpressure.
      araddr = 32'h10; arvalid = 1;
      tick();
      arvalid = 0;
      n = 0;
      while (!rvalid && n < 50) begin tick(); n++; end
      hold = rdata;
      chk("bp_rdata", hold, 32'hDEADBEEF);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("bp_rvalid%0d", k), 32'(rvalid), 32'd1);
         chk($sformatf("bp_rdata%0d", k), rdata, hold);
      end
      rready = 1;
      tick();
      rready = 0;
      chk("bp_release", 32'(rvalid), 32'd0);

      // Asynchronous reset while in LOAD_WAIT.
      araddr = 32'h10; arvalid = 1;
      tick();
      arvalid = 0;
      tick();
      chk("rstw_load", 32'(load_o), 32'd1);
      tick();
      rst_n = 0;
      #1;
      chk("rstw_rvalid", 32'(rvalid), 32'd0);
      chk("rstw_load_o", 32'(load_o), 32'd0);
      chk("rstw_rdata", rdata, 32'd0);
      chk("rstw_laddr", 32'(load_addr), 32'd0);
      chk("rstw_readys", {29'd0, arready, awready, wready}, 32'd7);
      tick(); tick();
      rst_n = 1;
      tick(); tick(); tick();
      chk("rstw_idle_rvalid", 32'(rvalid), 32'd0);
      axi_read(32'h10, r, d);
      chk("rstw_after_read", d, 32'hDEADBEEF);

      chk("no_overlap", 32'(n_ovl), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
